// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, 2-entry queue to decode.
// Response-to-decode latency 1 cycle; decode stall holds the head and fetch idles when the queue is full.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic        instr_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_t      state, state_nx;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   entry_t      q_mem [0:1];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count, count_nx;
   logic        push, pop;
   logic [31:0] redirect_aligned;
   logic        unused_bits;

   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   assign unused_bits      = ^redirect_pc[1:0];

   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid & ~stall & ~redirect_valid;
   // A response landing in a redirect cycle belongs to the old path and is dropped.
   assign push        = (state == WAIT) & imem_rvalid & ~redirect_valid;

   assign imem_req    = (state == FETCH);
   assign imem_addr   = fetch_pc;
   assign instruction = instr_valid ? q_mem[rd_ptr].instr : NOP_INSTR;
   assign pc_out      = instr_valid ? q_mem[rd_ptr].pc    : fetch_pc;

   always_comb begin
      count_nx = count;
      if (redirect_valid)
         count_nx = 2'd0;
      else
         count_nx = count + {1'b0, push} - {1'b0, pop};
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (redirect_valid || count < 2'd2) state_nx = FETCH;
         FETCH:   state_nx = redirect_valid ? DRAIN : WAIT;
         WAIT: begin
            if (imem_rvalid)
               state_nx = (redirect_valid || count_nx < 2'd2) ? FETCH : IDLE;
            else if (redirect_valid)
               state_nx = DRAIN;
         end
         DRAIN:   if (imem_rvalid) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (state == FETCH)
            req_pc <= fetch_pc;
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
         end else begin
            if (state == FETCH) fetch_pc <= fetch_pc + 32'd4;
            if (push)           wr_ptr   <= ~wr_ptr;
            if (pop)            rd_ptr   <= ~rd_ptr;
         end
      end
   end

   // Payload needs no reset: it is only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (reset && push)
         q_mem[wr_ptr] <= '{pc: req_pc, instr: imem_rdata};
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory responder plus an in-order fetch-stream reference model.
module tb_if_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction, pc_out;
   logic        instr_valid;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // memory responder state
   bit          mem_busy  = 0;
   bit          mem_stale = 0;
   int          mem_due   = 0;
   logic [31:0] mem_addr  = '0;
   int          mem_lat   = 1;
   bit          lat_rand  = 0;
   bit          rv_now    = 0;

   // reference model: words held for decode, next pc decode must see, next fetch address
   int          occ       = 0;
   logic [31:0] exp_pc    = RESET_PC;
   logic [31:0] exp_fetch = RESET_PC;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // One clock: apply inputs, answer memory, advance the model, then step to edge+1.
   task automatic drive(input bit st, input bit rd, input logic [31:0] tgt, input bit rst);
      logic [31:0] tgt_al;
      bit req, pop, push;
      tgt_al = {tgt[31:2], 2'b00};
      req    = imem_req;
      rv_now = mem_busy && (mem_due == cyc);
      stall = st; redirect_valid = rd; redirect_pc = tgt; reset = ~rst;
      imem_rvalid = rv_now;
      imem_rdata  = rv_now ? word_at(mem_addr) : $urandom;
      pop  = (occ > 0) && !st && !rd && !rst;
      push = rv_now && !mem_stale && !rd && !rst;
      if (rv_now) mem_busy = 0;
      if (pop) begin occ--; exp_pc += 32'd4; end
      if (push) occ++;
      if (req) begin
         mem_busy = 1; mem_stale = 0; mem_addr = imem_addr;
         mem_due  = cyc + (lat_rand ? int'($urandom_range(1, 4)) : mem_lat);
         exp_fetch += 32'd4;
      end
      if (rd)  begin occ = 0; exp_pc = tgt_al;   exp_fetch = tgt_al;   mem_stale = 1; end
      if (rst) begin occ = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC; mem_stale = 1; end
      @(posedge clk); #1; cyc++;
   endtask

   task automatic do_reset();
      lat_rand = 0; mem_lat = 1;
      for (int i = 0; i < 6; i++) drive(0, 0, 32'h0, 1);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
      n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
      n_cmp++; if (instruction !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
      n_cmp++; if (pc_out !== RESET_PC) begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc_out, RESET_PC); end
      drive(0, 0, 32'h0, 0);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         n_bad++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      int n_req = 0, last_req = -1, first_rv = -1, first_valid = -1;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (imem_req) begin
            n_cmp++;
            if (imem_addr !== 32'(n_req * 4)) begin
               n_bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, 32'(n_req * 4));
            end
            if (n_req > 0) begin
               n_cmp++;
               if (cyc - last_req != 2) begin n_bad++; $display("FAIL stream_gap: got %0d want 2", cyc - last_req); end
            end
            last_req = cyc; n_req++;
         end
         if (instr_valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            n_cmp++;
            if (pc_out !== exp_pc || instruction !== word_at(exp_pc)) begin
               n_bad++; $display("FAIL stream_head: got %h/%h want %h/%h", pc_out, instruction, exp_pc, word_at(exp_pc));
            end
         end
         drive(0, 0, 32'h0, 0);
         if (rv_now && first_rv < 0) first_rv = cyc;
      end
      n_cmp++;
      if (first_rv < 0 || first_valid != first_rv) begin
         n_bad++; $display("FAIL stream_first_valid: got cycle %0d want %0d", first_valid, first_rv);
      end
      n_cmp++; if (n_req < 15) begin n_bad++; $display("FAIL stream_count: got %0d want >=15", n_req); end
   endtask

   task automatic test_stall_fill();
      do_reset();
      for (int i = 0; i < 12; i++) drive(1, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instruction !== word_at(32'h0) || pc_out !== 32'h0) begin
            n_bad++; $display("FAIL full_hold: got req=%b v=%b %h/%h want 0 1 %h/00000000",
                              imem_req, instr_valid, instruction, pc_out, word_at(32'h0));
         end
         drive(1, 0, 32'h0, 0);
      end
      drive(0, 0, 32'h0, 0);
      n_cmp++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== word_at(32'h4)) begin
         n_bad++; $display("FAIL full_pop2: got v=%b %h/%h want 1 00000004/%h", instr_valid, pc_out, instruction, word_at(32'h4));
      end
      drive(0, 0, 32'h0, 0);
      for (int i = 0; i < 5 && imem_req !== 1'b1; i++) drive(0, 0, 32'h0, 0);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         n_bad++; $display("FAIL full_resume: got req=%b addr=%h want 1 00000008", imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      int r, req_cyc = -1;
      do_reset();
      mem_lat = 4;
      for (int i = 0; i < 10 && imem_req !== 1'b1; i++) drive(0, 0, 32'h0, 0);
      drive(0, 0, 32'h0, 0);
      r = cyc;
      drive(0, 1, 32'h0000_0103, 0);
      for (int i = 0; i < 15 && req_cyc < 0; i++) begin
         if (imem_req === 1'b1) req_cyc = cyc;
         else begin
            n_cmp++;
            if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rw_empty: got v=%b want 0", instr_valid); end
            drive(0, 0, 32'h0, 0);
         end
      end
      n_cmp++;
      if (req_cyc != r + 4 || imem_addr !== 32'h0000_0100) begin
         n_bad++; $display("FAIL rw_req: got cycle %0d addr %h want cycle %0d addr 00000100", req_cyc - r, imem_addr, 4);
      end
      for (int i = 0; i < 12 && instr_valid !== 1'b1; i++) drive(0, 0, 32'h0, 0);
      n_cmp++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instruction !== word_at(32'h100)) begin
         n_bad++; $display("FAIL rw_word: got v=%b %h/%h want 1 00000100/%h", instr_valid, pc_out, instruction, word_at(32'h100));
      end
   endtask

   task automatic test_redirect_rvalid_pop();
      do_reset();
      for (int i = 0; i < 20 && !(occ == 1 && mem_busy && mem_due == cyc); i++) drive(1, 0, 32'h0, 0);
      n_cmp++;
      if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL rp_setup: got v=%b want 1", instr_valid); end
      drive(0, 1, 32'h0000_0208, 0);
      n_cmp++;
      if (!rv_now) begin n_bad++; $display("FAIL rp_align: got rvalid=0 want 1 in redirect cycle"); end
      n_cmp++;
      if (instr_valid !== 1'b0 || instruction !== NOP) begin
         n_bad++; $display("FAIL rp_flush: got v=%b %h want 0 %h", instr_valid, instruction, NOP);
      end
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0208) begin
         n_bad++; $display("FAIL rp_req: got req=%b addr=%h want 1 00000208", imem_req, imem_addr);
      end
      for (int i = 0; i < 6 && instr_valid !== 1'b1; i++) drive(1, 0, 32'h0, 0);
      n_cmp++;
      if (pc_out !== 32'h208 || instruction !== word_at(32'h208)) begin
         n_bad++; $display("FAIL rp_word: got %h/%h want 00000208/%h", pc_out, instruction, word_at(32'h208));
      end
   endtask

   task automatic test_wrap();
      logic [31:0] addrs [$];
      do_reset();
      for (int i = 0; i < 10 && imem_req !== 1'b1; i++) drive(0, 0, 32'h0, 0);
      drive(0, 1, 32'hFFFF_FFFE, 0);
      for (int i = 0; i < 12; i++) begin
         if (imem_req === 1'b1) addrs.push_back(imem_addr);
         drive(0, 0, 32'h0, 0);
      end
      n_cmp++;
      if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
         n_bad++; $display("FAIL wrap: got %0d reqs first %h second %h want FFFFFFFC 00000000",
                           addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hx, (addrs.size() > 1) ? addrs[1] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_lat = 2;
      for (int i = 0; i < 10 && imem_req !== 1'b1; i++) drive(0, 0, 32'h0, 0);
      drive(0, 0, 32'h0, 0);
      drive(0, 0, 32'h0, 1);
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         n_bad++; $display("FAIL rm_idle: got req=%b v=%b want 0 0", imem_req, instr_valid);
      end
      drive(0, 0, 32'h0, 0);
      n_cmp++;
      if (!rv_now) begin n_bad++; $display("FAIL rm_align: got rvalid=0 want 1 after reset"); end
      n_cmp++;
      if (instr_valid !== 1'b0 || instruction !== NOP) begin
         n_bad++; $display("FAIL rm_ignore: got v=%b %h want 0 %h", instr_valid, instruction, NOP);
      end
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         n_bad++; $display("FAIL rm_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_random();
      int pops = 0;
      bit st, rd;
      logic [31:0] tgt;
      do_reset();
      lat_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         n_cmp++;
         if (instr_valid !== (occ != 0)) begin n_bad++; $display("FAIL rnd_valid: got %b want %b", instr_valid, occ != 0); end
         if (occ != 0) begin
            n_cmp++;
            if (pc_out !== exp_pc || instruction !== word_at(exp_pc)) begin
               n_bad++; $display("FAIL rnd_head: got %h/%h want %h/%h", pc_out, instruction, exp_pc, word_at(exp_pc));
            end
         end else begin
            n_cmp++;
            if (instruction !== NOP || pc_out !== exp_fetch) begin
               n_bad++; $display("FAIL rnd_empty: got %h/%h want %h/%h", instruction, pc_out, NOP, exp_fetch);
            end
         end
         if (imem_req === 1'b1) begin
            n_cmp++;
            if (imem_addr !== exp_fetch || mem_busy) begin
               n_bad++; $display("FAIL rnd_req: got addr %h outstanding=%b want %h 0", imem_addr, mem_busy, exp_fetch);
            end
         end
         st  = ($urandom_range(0, 9) < 3);
         rd  = ($urandom_range(0, 19) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         if (occ > 0 && !st && !rd) pops++;
         drive(st, rd, tgt, 0);
      end
      n_cmp++;
      if (pops < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d pops want >=100", pops); end
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      @(posedge clk); #1;
      test_reset();
      test_stream();
      test_stall_fill();
      test_redirect_wait();
      test_redirect_rvalid_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
